// File: rtl/cnn_train_scheduler.sv
// cnn_train_scheduler: steps cnn_top through every image of every epoch,
// tracking per-epoch accuracy and guarding each pass with a timeout.
module cnn_train_scheduler #(
    parameter int NUM_IMAGES     = 1000,
    parameter int FCL_OUTPUT_DIM = 10,
    parameter int EPOCH_W        = 8,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [EPOCH_W-1:0]                num_epochs,
    input  logic                              train_mode,
    input  logic                              pause,
    input  logic                              abort,
    output logic [$clog2(NUM_IMAGES)-1:0]     img_index,
    output logic                              cnn_start,
    output logic                              cnn_train,
    input  logic                              cnn_done,
    input  logic [$clog2(FCL_OUTPUT_DIM)-1:0] pred_class,
    input  logic [$clog2(FCL_OUTPUT_DIM)-1:0] label_class,
    output logic                              busy,
    output logic [EPOCH_W-1:0]                epoch,
    output logic                              epoch_done,
    output logic [$clog2(NUM_IMAGES+1)-1:0]   last_epoch_correct,
    output logic                              done,
    output logic                              error
);
    localparam int IW = $clog2(NUM_IMAGES);
    localparam int CW = $clog2(NUM_IMAGES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [IW-1:0]      LAST_IDX    = IW'(NUM_IMAGES - 1);
    localparam logic [SW-1:0]      SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]      TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [EPOCH_W-1:0] EP_ONE      = EPOCH_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IW-1:0]      r_index;
    logic [EPOCH_W-1:0] r_epoch;
    logic [EPOCH_W-1:0] r_num_epochs;
    logic [CW-1:0]      r_correct;
    logic [CW-1:0]      r_last_correct;
    logic [SW-1:0]      r_settle;
    logic [TW-1:0]      r_timer;
    logic               r_train;
    logic               r_error;
    logic               r_cnn_start;
    logic               r_epoch_done;
    logic               r_done;

    logic w_last_img;
    logic w_last_ep;
    logic w_settled;
    logic w_timeout;
    logic w_hit;
    logic w_cnn_start;
    logic w_epoch_done;
    logic w_done;

    assign w_last_img = (r_index == LAST_IDX);
    assign w_last_ep  = (r_epoch == r_num_epochs - EP_ONE);
    assign w_settled  = !pause && (r_settle == SETTLE_LAST);
    assign w_timeout  = (r_timer == TIMER_LAST);
    assign w_hit      = (pred_class == label_class);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (num_epochs == '0) ? S_FINISH : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort)          w_next = S_FINISH;
                else if (w_settled) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_next = abort ? S_FINISH : S_WAIT;
            end
            S_WAIT: begin
                if (abort)          w_next = S_FINISH;
                else if (cnn_done)  w_next = S_ADVANCE;
                else if (w_timeout) w_next = S_FINISH;
            end
            S_ADVANCE: begin
                if (abort)                        w_next = S_FINISH;
                else if (w_last_img && w_last_ep) w_next = S_FINISH;
                else                              w_next = S_SETTLE;
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_cnn_start  = 1'b0;
        w_epoch_done = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            S_ISSUE:   w_cnn_start  = !abort;
            S_ADVANCE: w_epoch_done = !abort && w_last_img;
            S_FINISH:  w_done       = 1'b1;
            default:   w_done       = 1'b0;
        endcase
    end

    // Pulses are registered so they reach cnn_top glitch-free.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_index        <= '0;
            r_epoch        <= '0;
            r_num_epochs   <= '0;
            r_correct      <= '0;
            r_last_correct <= '0;
            r_settle       <= '0;
            r_timer        <= '0;
            r_train        <= 1'b0;
            r_error        <= 1'b0;
            r_cnn_start    <= 1'b0;
            r_epoch_done   <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_cnn_start  <= w_cnn_start;
            r_epoch_done <= w_epoch_done;
            r_done       <= w_done;
            r_settle     <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_epochs <= num_epochs;
                        r_train      <= train_mode;
                        r_error      <= 1'b0;
                        r_index      <= '0;
                        r_epoch      <= '0;
                        r_correct    <= '0;
                    end
                end
                S_SETTLE: begin
                    r_settle <= pause ? r_settle : r_settle + 1'b1;
                end
                S_ISSUE: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    if (!abort) begin
                        if (cnn_done) begin
                            r_correct <= r_correct + CW'(w_hit);
                        end else if (w_timeout) begin
                            r_error <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                S_ADVANCE: begin
                    if (!abort) begin
                        if (!w_last_img) begin
                            r_index <= r_index + 1'b1;
                        end else begin
                            r_last_correct <= r_correct;
                            r_correct      <= '0;
                            if (!w_last_ep) begin
                                r_epoch <= r_epoch + EP_ONE;
                                r_index <= '0;
                            end
                        end
                    end
                end
                default: begin
                    r_timer <= r_timer;
                end
            endcase
        end
    end

    assign img_index          = r_index;
    assign cnn_start          = r_cnn_start;
    assign cnn_train          = r_train;
    assign busy               = (r_state != S_IDLE);
    assign epoch              = r_epoch;
    assign epoch_done         = r_epoch_done;
    assign last_epoch_correct = r_last_correct;
    assign done               = r_done;
    assign error              = r_error;

endmodule

// File: tb/tb_cnn_train_scheduler.sv
// tb_cnn_train_scheduler: emulates cnn_top and checks the scheduler's
// start/epoch/done pulses against an image-by-image run model.
module tb_cnn_train_scheduler;
    localparam int NI  = 4;
    localparam int NC  = 10;
    localparam int EW  = 8;
    localparam int SC  = 2;
    localparam int TO  = 16;
    localparam int IW  = $clog2(NI);
    localparam int CLW = $clog2(NC);
    localparam int LW  = $clog2(NI + 1);

    localparam int K_START = 0;
    localparam int K_EPOCH = 1;
    localparam int K_DONE  = 2;

    localparam int M_RND  = 0;
    localparam int M_T1   = 1;
    localparam int M_TO   = 2;
    localparam int M_EDGE = 3;
    localparam int M_AB2  = 4;

    typedef struct {
        int k;
        int idx;
        int ep;
        int v;
        int er;
    } ev_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [EW-1:0]  num_epochs = '0;
    logic           train_mode = 1'b0;
    logic           pause = 1'b0;
    logic           abort = 1'b0;
    logic           cnn_done = 1'b0;
    logic [CLW-1:0] pred_class = '0;
    logic [CLW-1:0] label_class = '0;
    logic [IW-1:0]  img_index;
    logic           cnn_start;
    logic           cnn_train;
    logic           busy;
    logic [EW-1:0]  epoch;
    logic           epoch_done;
    logic [LW-1:0]  last_epoch_correct;
    logic           done;
    logic           error;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_act_start = 0;
    int  busy_cyc = 0;

    cnn_train_scheduler #(
        .NUM_IMAGES    (NI),
        .FCL_OUTPUT_DIM(NC),
        .EPOCH_W       (EW),
        .SETTLE_CYCLES (SC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .num_epochs        (num_epochs),
        .train_mode        (train_mode),
        .pause             (pause),
        .abort             (abort),
        .img_index         (img_index),
        .cnn_start         (cnn_start),
        .cnn_train         (cnn_train),
        .cnn_done          (cnn_done),
        .pred_class        (pred_class),
        .label_class       (label_class),
        .busy              (busy),
        .epoch             (epoch),
        .epoch_done        (epoch_done),
        .last_epoch_correct(last_epoch_correct),
        .done              (done),
        .error             (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input int idx, input int ep,
                        input int v, input int er);
        ev_t x;
        x.k = k; x.idx = idx; x.ep = ep; x.v = v; x.er = er;
        exp_q.push_back(x);
    endtask

    task automatic check_ev(input int k, input int idx, input int ep,
                            input int v, input int er);
        ev_t x;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d idx=%0d ep=%0d val=%0d err=%0d, expected none",
                     k, idx, ep, v, er);
            return;
        end
        x = exp_q.pop_front();
        if (x.k != k || x.idx != idx || x.ep != ep || x.v != v || x.er != er) begin
            n_bad++;
            $display("FAIL event: got kind=%0d idx=%0d ep=%0d val=%0d err=%0d, expected kind=%0d idx=%0d ep=%0d val=%0d err=%0d",
                     k, idx, ep, v, er, x.k, x.idx, x.ep, x.v, x.er);
        end
    endtask

    // Monitor: every output pulse is matched against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (cnn_start) begin
                    n_act_start++;
                    check_ev(K_START, int'(img_index), int'(epoch),
                             int'(cnn_train), int'(error));
                end
                if (epoch_done) begin
                    check_ev(K_EPOCH, int'(img_index), int'(epoch),
                             int'(last_epoch_correct), int'(error));
                end
                if (done) begin
                    check_ev(K_DONE, int'(img_index), int'(epoch), 0, int'(error));
                end
            end
        end
    end

    task automatic wait_for(input int which, input int lim, input int pz,
                            output int cyc);
        logic s;
        busy_cyc = 0;
        for (int c = 1; c <= lim; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start    = 1'b0;
                cnn_done = 1'b0;
                abort    = 1'b0;
            end
            pause = (c <= pz);
            if (busy) busy_cyc++;
            s = (which == 0) ? cnn_start : done;
            if (s) begin
                cyc   = c;
                pause = 1'b0;
                return;
            end
        end
        cyc = -1;
        n_cmp++;
        n_bad++;
        $display("FAIL wait_%s: no pulse within %0d cycles",
                 (which == 0) ? "cnn_start" : "done", lim);
    endtask

    task automatic recover();
        @(negedge clk);
        start = 1'b0; cnn_done = 1'b0; abort = 1'b0; pause = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        reset = 1'b1;
    endtask

    task automatic run(input int ne, input bit tr, input int pz, input int mode);
        int cyc, d, act, hits, st0, nexp, r;
        bit hit, stop, both;
        logic [CLW-1:0] pc;
        st0  = n_act_start;
        nexp = 0;
        stop = 1'b0;
        @(negedge clk);
        num_epochs = EW'(ne);
        train_mode = tr;
        start      = 1'b1;
        if (ne == 0) begin
            push(K_DONE, 0, 0, 0, 0);
            wait_for(1, 20, 0, cyc);
            chk("zero_epoch_done_lat", cyc, 2);
            chk("zero_epoch_busy_cycles", busy_cyc, 1);
            chk("zero_epoch_starts", n_act_start - st0, 0);
            return;
        end
        for (int e = 0; e < ne && !stop; e++) begin
            hits = 0;
            for (int i = 0; i < NI && !stop; i++) begin
                push(K_START, i, e, int'(tr), 0);
                nexp++;
                wait_for(0, 60, (e == 0 && i == 0) ? pz : 0, cyc);
                if (cyc < 0) begin
                    recover();
                    return;
                end
                if (e == 0 && i == 0) chk("start_to_cnn_start", cyc, SC + 2 + pz);
                else                  chk("done_to_cnn_start", cyc, SC + 3);
                hit  = ($urandom % 2) == 1;
                both = ($urandom % 2) == 1;
                act  = 0;
                d    = 3;
                case (mode)
                    M_T1:   hit = (i % 2 == 0);
                    M_TO:   act = (i == 0) ? 1 : 0;
                    M_EDGE: d = TO - 1;
                    M_AB2: begin
                        act = (e == 0 && i == 2) ? 2 : 0;
                        if (act == 2) begin d = 1; both = 1'b0; end
                    end
                    default: begin
                        r = $urandom_range(0, 99);
                        act = (r < 4) ? 1 : ((r < 10) ? 2 : 0);
                        d = ($urandom % 5 == 0) ? TO - 1 : $urandom_range(0, TO - 1);
                    end
                endcase
                if (act == 1) d = 0;
                for (int j = 0; j < d; j++) begin
                    start      = ($urandom % 6 == 0);
                    num_epochs = EW'($urandom);
                    @(negedge clk);
                end
                start = 1'b0;
                pc = CLW'($urandom_range(0, NC - 1));
                pred_class  = pc;
                label_class = hit ? pc : CLW'((int'(pc) + 1 + $urandom_range(0, NC - 2)) % NC);
                if (act == 0) begin
                    cnn_done = 1'b1;
                    if (hit) hits++;
                    if (i == NI - 1) begin
                        push(K_EPOCH, (e == ne - 1) ? NI - 1 : 0,
                             (e == ne - 1) ? e : e + 1, hits, 0);
                        if (e == ne - 1) begin
                            push(K_DONE, NI - 1, e, 0, 0);
                            wait_for(1, 20, 0, cyc);
                            chk("last_done_lat", cyc, 3);
                            chk("busy_after_done", int'(busy), 0);
                        end
                    end
                end else if (act == 2) begin
                    abort    = 1'b1;
                    cnn_done = both;
                    push(K_DONE, i, e, 0, 0);
                    wait_for(1, 20, 0, cyc);
                    chk("abort_done_lat", cyc, 2);
                    chk("busy_after_abort", int'(busy), 0);
                    stop = 1'b1;
                end else begin
                    push(K_DONE, i, e, 0, 1);
                    wait_for(1, TO + 10, 0, cyc);
                    chk("timeout_done_lat", cyc, TO + 1);
                    stop = 1'b1;
                end
            end
        end
        chk("cnn_start_count", n_act_start - st0, nexp);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_img_index", int'(img_index), 0);
        chk("rst_epoch", int'(epoch), 0);
        chk("rst_last_correct", int'(last_epoch_correct), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_pulses", int'({cnn_start, epoch_done, done}), 0);
        chk("rst_cnn_train", int'(cnn_train), 0);

        run(2, 1'b1, 0, M_T1);
        chk("t1_last_epoch_correct", int'(last_epoch_correct), 2);
        chk("t1_hold_epoch", int'(epoch), 1);

        run(0, 1'b0, 0, M_RND);

        run(1, 1'b0, 0, M_TO);
        chk("t3_error_sticky", int'(error), 1);
        run(1, 1'b0, 0, M_T1);
        chk("t3_error_cleared", int'(error), 0);

        run(1, 1'b1, 5, M_T1);
        run(2, 1'b0, 0, M_EDGE);
        chk("t6_no_error", int'(error), 0);
        run(2, 1'b1, 0, M_AB2);

        for (int k = 0; k < 15; k++) begin
            run($urandom_range(1, 3), ($urandom % 2) == 1,
                $urandom_range(0, 3), M_RND);
        end

        @(negedge clk);
        num_epochs = 8'd2;
        train_mode = 1'b1;
        start      = 1'b1;
        push(K_START, 0, 0, 1, 0);
        wait_for(0, 60, 0, cyc);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_wait_reset_outs",
            int'({busy, cnn_start, cnn_train, done, epoch_done, error,
                  img_index, epoch, last_epoch_correct}), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_after_reset", int'(busy), 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
